// File: rtl/led_pattern_engine.sv
// -----------------------------------------------------------------------------
// led_pattern_engine
//
// This is an LED pattern sequencer that runs entirely in the clk domain.
// A free-running prescaler produces a step strobe once every 2^DIV_BITS
// enabled cycles. On each step, the LED register advances by one position
// of the selected pattern, or it reloads that pattern's seed if the mode
// selection has changed.
//
// Parameters
//   WIDTH    : number of LEDs (>= 2)
//   DIV_BITS : prescaler width; one step per 2^DIV_BITS enabled cycles (>= 1)
//
// Ports
//   clk   in   system clock, rising edge
//   rst   in   asynchronous reset, active low
//   en    in   run enable; prescaler and pattern freeze while low
//   mode  in   pattern select: 0 rotate left, 1 rotate right, 2 bounce,
//              3 counter (sampled only at steps)
//   led   out  LED drive (registered)
//   tick  out  one-cycle pulse coincident with each new led value
//   wrap  out  one-cycle pulse when the pattern returns to its seed
//
// Build option
//   LEDSEQ_GRAY_EN : when defined, the counter mode drives led with the
//                    Gray code of the internal counter instead of the
//                    plain binary value.
// -----------------------------------------------------------------------------
//
// State table:
//   state                | meaning
//   ---------------------+----------------------------------------------------
//   mode_q = MODE_ROL    | rotating left, MSB wraps into bit 0
//   mode_q = MODE_ROR    | rotating right, bit 0 wraps into MSB
//   mode_q = MODE_BOUNCE | single lit LED walking between the ends;
//                        |   dir = DIR_LEFT  -> moving toward the MSB
//                        |   dir = DIR_RIGHT -> moving toward bit 0
//   mode_q = MODE_COUNT  | led shows the binary (or Gray) image of bin
// -----------------------------------------------------------------------------

module led_pattern_engine #(
  parameter int WIDTH    = 16,
  parameter int DIV_BITS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] led,
  output logic             tick,
  output logic             wrap
);

  typedef enum logic [1:0] {
    MODE_ROL    = 2'd0,
    MODE_ROR    = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  localparam logic [WIDTH-1:0]    LED_SEED = WIDTH'(1);
  localparam logic [DIV_BITS-1:0] CNT_ONE  = DIV_BITS'(1);
  localparam logic [DIV_BITS-1:0] CNT_LAST = '1;
  localparam logic [WIDTH-1:0]    BIN_ONE  = WIDTH'(1);

  logic [DIV_BITS-1:0] cnt;
  logic [WIDTH-1:0]    bin;
  mode_t               mode_q;
  dir_t                dir;

  logic                step;
  logic                mode_change;
  logic [WIDTH-1:0]    led_rol;
  logic [WIDTH-1:0]    led_ror;
  logic [WIDTH-1:0]    led_shl;
  logic [WIDTH-1:0]    led_shr;
  logic [WIDTH-1:0]    bin_inc;

  // Counter-mode LED image. Wrap detection always looks at bin itself, so
  // the choice of encoding has no effect on step or wrap timing.
  function automatic logic [WIDTH-1:0] led_from_bin(input logic [WIDTH-1:0] b);
`ifdef LEDSEQ_GRAY_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  always_comb begin
    step        = en && (cnt == CNT_LAST);
    mode_change = (mode != mode_q);
    led_rol     = {led[WIDTH-2:0], led[WIDTH-1]};
    led_ror     = {led[0], led[WIDTH-1:1]};
    led_shl     = led << 1;
    led_shr     = led >> 1;
    bin_inc     = bin + BIN_ONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      bin    <= '0;
      mode_q <= MODE_ROL;
      dir    <= DIR_LEFT;
      led    <= LED_SEED;
      tick   <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;

      if (en) begin
        cnt <= cnt + CNT_ONE;
      end

      if (step) begin
        tick <= 1'b1;
        if (mode_change) begin
          // A new selection only takes effect at a step, starting from its seed.
          mode_q <= mode_t'(mode);
          if (mode_t'(mode) == MODE_COUNT) begin
            bin <= '0;
            led <= led_from_bin('0);
          end else begin
            led <= LED_SEED;
            dir <= DIR_LEFT;
          end
        end else begin
          unique case (mode_q)
            MODE_ROL: begin
              led  <= led_rol;
              wrap <= (led_rol == LED_SEED);
            end
            MODE_ROR: begin
              led  <= led_ror;
              wrap <= (led_ror == LED_SEED);
            end
            MODE_BOUNCE: begin
              // Direction flips on the step that lands on an end bit, so
              // each end is lit for exactly one step per pass.
              if (dir == DIR_LEFT) begin
                led <= led_shl;
                if (led_shl[WIDTH-1]) begin
                  dir <= DIR_RIGHT;
                end
              end else begin
                led <= led_shr;
                if (led_shr[0]) begin
                  dir  <= DIR_LEFT;
                  wrap <= 1'b1;
                end
              end
            end
            MODE_COUNT: begin
              bin  <= bin_inc;
              led  <= led_from_bin(bin_inc);
              wrap <= (bin_inc == '0);
            end
            default: begin
              led <= LED_SEED;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_engine.sv
module tb_led_pattern_engine;

  localparam int DIVB = 2;
  localparam int PER  = 1 << DIVB;

  logic        clk;
  logic        rst;
  logic        en;
  logic [1:0]  mode;
  logic [15:0] led_a;
  logic        tick_a;
  logic        wrap_a;
  logic [3:0]  led_b;
  logic        tick_b;
  logic        wrap_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: an enabled-cycle counter plus, per instance, a phase
  // within the active pattern (LED position or bounce phase) and a counter value.
  int wdt[2] = '{16, 4};
  int m_ecnt;
  int m_mq;
  int m_phase[2];
  int m_bin[2];
  bit m_tick;
  bit m_wrap[2];

  led_pattern_engine #(.WIDTH(16), .DIV_BITS(DIVB)) u_w16 (
    .clk (clk), .rst (rst), .en (en), .mode (mode),
    .led (led_a), .tick (tick_a), .wrap (wrap_a)
  );

  led_pattern_engine #(.WIDTH(4), .DIV_BITS(DIVB)) u_w4 (
    .clk (clk), .rst (rst), .en (en), .mode (mode),
    .led (led_b), .tick (tick_b), .wrap (wrap_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_ecnt = 0;
    m_mq   = 0;
    m_tick = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_phase[i] = 0;
      m_bin[i]   = 0;
      m_wrap[i]  = 1'b0;
    end
  endfunction

  function automatic void model_edge();
    int w;
    if (!rst) begin
      model_reset();
      return;
    end
    m_tick = 1'b0;
    for (int i = 0; i < 2; i++) m_wrap[i] = 1'b0;
    if (!en) return;
    m_ecnt++;
    if (m_ecnt % PER != 0) return;
    m_tick = 1'b1;
    if (int'(mode) != m_mq) begin
      m_mq = int'(mode);
      for (int i = 0; i < 2; i++) begin
        m_phase[i] = 0;
        m_bin[i]   = 0;
      end
      return;
    end
    for (int i = 0; i < 2; i++) begin
      w = wdt[i];
      case (m_mq)
        0: begin
          m_phase[i] = (m_phase[i] + 1) % w;
          m_wrap[i]  = (m_phase[i] == 0);
        end
        1: begin
          m_phase[i] = (m_phase[i] + w - 1) % w;
          m_wrap[i]  = (m_phase[i] == 0);
        end
        2: begin
          m_phase[i] = (m_phase[i] + 1) % (2 * w - 2);
          m_wrap[i]  = (m_phase[i] == 0);
        end
        default: begin
          m_bin[i]  = (m_bin[i] + 1) % (1 << w);
          m_wrap[i] = (m_bin[i] == 0);
        end
      endcase
    end
  endfunction

  function automatic int exp_led(input int i);
    int w;
    int p;
    w = wdt[i];
    p = m_phase[i];
    case (m_mq)
      0, 1: return 1 << p;
      2:    return 1 << ((p < w) ? p : (2 * w - 2 - p));
      default: begin
`ifdef LEDSEQ_GRAY_EN
        return m_bin[i] ^ (m_bin[i] >> 1);
`else
        return m_bin[i];
`endif
      end
    endcase
  endfunction

  task automatic check_outputs();
    chk("led16",  32'(led_a),  32'(exp_led(0)));
    chk("tick16", 32'(tick_a), 32'(m_tick));
    chk("wrap16", 32'(wrap_a), 32'(m_wrap[0]));
    chk("led4",   32'(led_b),  32'(exp_led(1)));
    chk("tick4",  32'(tick_b), 32'(m_tick));
    chk("wrap4",  32'(wrap_b), 32'(m_wrap[1]));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  // Called one time unit after a rising edge: reset is asserted between
  // edges and must take effect without a clock.
  task automatic pulse_reset();
    rst = 1'b0;
    #1;
    chk("async_rst_led16",  32'(led_a),  32'h1);
    chk("async_rst_tick16", 32'(tick_a), 32'h0);
    chk("async_rst_led4",   32'(led_b),  32'h1);
    model_reset();
    cycle();
    cycle();
    rst = 1'b1;
  endtask

  int wraps_a;
  int wraps_b;
  int seg_len;

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    mode = 2'd0;
    #2;
    rst = 1'b0;
    #1;
    chk("reset_led16",  32'(led_a),  32'h1);
    chk("reset_tick16", 32'(tick_a), 32'h0);
    chk("reset_wrap16", 32'(wrap_a), 32'h0);
    model_reset();
    cycle();
    cycle();
    rst  = 1'b1;
    en   = 1'b1;
    mode = 2'd0;

    // Rotate left: first step on the 4th edge, wrap on the 16th step.
    for (int k = 1; k <= 64; k++) begin
      cycle();
      if (k == 3) chk("pre_step_tick", 32'(tick_a), 32'h0);
      if (k == 4) begin
        chk("first_step_led",  32'(led_a),  32'h2);
        chk("first_step_tick", 32'(tick_a), 32'h1);
      end
      if (k == 5) chk("tick_one_cycle", 32'(tick_a), 32'h0);
    end
    chk("rol_wrap_led",  32'(led_a),  32'h1);
    chk("rol_wrap_flag", 32'(wrap_a), 32'h1);

    // Bounce from reset: step 1 reloads the seed, then there is one 30-step pass.
    pulse_reset();
    mode    = 2'd2;
    wraps_a = 0;
    wraps_b = 0;
    for (int k = 1; k <= 31 * PER + 2; k++) begin
      cycle();
      if (k == 16 * PER) chk("bounce_msb", 32'(led_a), 32'h8000);
      if (k == 17 * PER) chk("bounce_back", 32'(led_a), 32'h4000);
      wraps_a += int'(wrap_a);
      wraps_b += int'(wrap_b);
    end
    chk("bounce16_wraps", 32'(wraps_a), 32'd1);
    chk("bounce4_wraps",  32'(wraps_b), 32'd5);

    // Async reset mid-run in bounce, then restart.
    for (int k = 0; k < 5 * PER + 1; k++) cycle();
    pulse_reset();
    for (int k = 0; k < 3 * PER; k++) cycle();
    chk("bounce_restart", 32'(led_a), 32'h4);

    // Counter mode on the 4-bit instance: reload, 0x1..0xF, then wrap to 0.
    pulse_reset();
    mode    = 2'd3;
    wraps_b = 0;
    for (int k = 1; k <= 17 * PER; k++) begin
      cycle();
      if (k == PER) chk("count_reload_wrap", 32'(wrap_b), 32'h0);
      wraps_b += int'(wrap_b);
    end
    chk("count_wrap_flag", 32'(wrap_b), 32'h1);
    chk("count_wraps",     32'(wraps_b), 32'd1);
    chk("count_wrap_led",  32'(led_b),  32'h0);

    // Enable freeze: 2 enabled edges, 10 disabled, step on 2nd re-enabled edge.
    pulse_reset();
    mode = 2'd0;
    cycle();
    cycle();
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      chk("freeze_led", 32'(led_a), 32'h1);
    end
    en = 1'b1;
    cycle();
    chk("reenable_no_tick", 32'(tick_a), 32'h0);
    cycle();
    chk("reenable_tick", 32'(tick_a), 32'h1);
    chk("reenable_led",  32'(led_a),  32'h2);

    // Mode switch from rotate-left at 0x0010 to rotate-right.
    pulse_reset();
    mode = 2'd0;
    for (int k = 0; k < 4 * PER; k++) cycle();
    chk("switch_start", 32'(led_a), 32'h10);
    mode = 2'd1;
    for (int k = 0; k < PER; k++) cycle();
    chk("switch_reload_led",  32'(led_a),  32'h1);
    chk("switch_reload_wrap", 32'(wrap_a), 32'h0);
    for (int k = 0; k < PER; k++) cycle();
    chk("switch_ror_led",  32'(led_a),  32'h8000);
    chk("switch_ror_wrap", 32'(wrap_a), 32'h0);

    // Randomised segments: random mode, enable pattern and occasional resets.
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(0, 7) == 0) pulse_reset();
      mode    = 2'($urandom_range(0, 3));
      seg_len = $urandom_range(8, 150);
      for (int k = 0; k < seg_len; k++) begin
        en = ($urandom_range(0, 9) != 0);
        cycle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
